// File: rtl/polyphase_upsampler_32_48.sv
// 3/2 polyphase resampler (32 kHz -> 48 kHz): 16-tap serial MAC per output against an external registered coefficient ROM.
// Latency: input handshake at cycle N -> out_valid_o at N+18; a phase-0 output handshake -> next (phase-2) out_valid_o 18 cycles later.
// Backpressure: out_valid_o/out_data_o hold until out_ready_i; in_ready_o is low outside WAIT_IN, so no input is taken while an output is pending.
module polyphase_upsampler_32_48 #(
  parameter int TAPS   = 16,
  parameter int PHASES = 3,
  parameter int DECIM  = 2,
  parameter int ACCW   = 52
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [5:0]  rom_addr_o,
  input  logic [23:0] rom_data_i,
  output logic [23:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  typedef enum logic [1:0] {
    WAIT_IN = 2'd0,
    MAC     = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t                  state_q;
  logic [1:0]              phase_q;
  logic [4:0]              tap_q;
  logic signed [23:0]      hist_q [TAPS];
  logic signed [ACCW-1:0]  acc_q;
  logic [5:0]              rom_addr_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [23:0]             out_data_q;

  logic [3:0]              hsel_d;
  logic signed [47:0]      prod_d;
  logic signed [ACCW-1:0]  acc_d;
  logic [23:0]             sat_d;
  logic [2:0]              phase_sum_d;
  logic                    consume_d;
  logic [1:0]              phase_d;

  assign in_ready_o  = in_ready_q;
  assign rom_addr_o  = rom_addr_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  // First coefficient address of a phase: phase-major ROM layout.
  function automatic logic [5:0] base_addr(input logic [1:0] ph);
    return 6'(ph) * 6'(TAPS);
  endfunction

  // The ROM word arriving now belongs to the address issued last cycle, so pair it with the previous tap's sample.
  always_comb begin
    hsel_d = tap_q[3:0] - 4'd1;
    prod_d = $signed(rom_data_i) * hist_q[hsel_d];
    acc_d  = acc_q;
    if (state_q == MAC && tap_q != 5'd0) begin
      acc_d = acc_q + ACCW'(prod_d);
    end
  end

  // Drop the 23 fraction bits and clamp to 24-bit signed; in range only when all bits above bit 46 match the sign.
  always_comb begin
    sat_d = acc_d[46:23];
    if (!((&acc_d[ACCW-1:46]) || !(|acc_d[ACCW-1:46]))) begin
      sat_d = acc_d[ACCW-1] ? 24'h800000 : 24'h7FFFFF;
    end
  end

  // Phase step after each output: advance by DECIM modulo PHASES; a wrap means one fresh input is needed.
  always_comb begin
    phase_sum_d = 3'(phase_q) + 3'(DECIM);
    consume_d   = (phase_sum_d >= 3'(PHASES));
    phase_d     = consume_d ? 2'(phase_sum_d - 3'(PHASES)) : phase_sum_d[1:0];
  end

  // Control FSM with history shift, MAC accumulation and registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WAIT_IN;
      phase_q     <= 2'd0;
      tap_q       <= 5'd0;
      acc_q       <= '0;
      rom_addr_q  <= 6'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 24'd0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        WAIT_IN: begin
          in_ready_q <= 1'b1;
          rom_addr_q <= 6'd0;
          if (in_valid_i && in_ready_q) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              hist_q[i] <= hist_q[i-1];
            end
            hist_q[0]  <= $signed(in_data_i);
            in_ready_q <= 1'b0;
            tap_q      <= 5'd0;
            acc_q      <= '0;
            rom_addr_q <= base_addr(phase_q);
            state_q    <= MAC;
          end
        end

        MAC: begin
          acc_q <= acc_d;
          if (tap_q == 5'(TAPS)) begin
            // Drain cycle: the last product lands in acc_d, so the output is formed from it directly.
            out_data_q  <= sat_d;
            out_valid_q <= 1'b1;
            tap_q       <= 5'd0;
            rom_addr_q  <= 6'd0;
            state_q     <= OUT;
          end else begin
            tap_q      <= tap_q + 5'd1;
            rom_addr_q <= (tap_q == 5'(TAPS - 1)) ? 6'd0 : rom_addr_q + 6'd1;
          end
        end

        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            phase_q     <= phase_d;
            if (consume_d) begin
              in_ready_q <= 1'b1;
              state_q    <= WAIT_IN;
            end else begin
              tap_q      <= 5'd0;
              acc_q      <= '0;
              rom_addr_q <= base_addr(phase_d);
              state_q    <= MAC;
            end
          end
        end

        default: begin
          state_q <= WAIT_IN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_upsampler_32_48.sv
// Bench for the 3/2 polyphase resampler: directed steps with random data, checked against a direct polyphase formula.
// The coefficient ROM is modelled here as a registered 48-word table (one-cycle read latency).
// Sampling happens on the falling edge; inputs change 1 time unit after the rising edge.
module tb_polyphase_upsampler_32_48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] in_data = 24'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  rom_addr;
  logic [23:0] rom_data = 24'd0;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  int rom [64];
  int xs [$];
  int outs [$];
  int nout = 0;
  bit pend = 1'b0;
  int trig_cyc = 0;
  bit prev_vld = 1'b0;

  polyphase_upsampler_32_48 dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= 24'(rom[rom_addr]);

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output j is upsampled index 2j: phase (2j mod 3), newest input floor(2j/3).
  function automatic int model_out(input int j);
    int p = (2 * j) % 3;
    int i = (2 * j) / 3;
    longint acc = 0;
    for (int t = 0; t < 16; t++) begin
      if (i - t >= 0 && i - t < xs.size()) begin
        acc += longint'(rom[p * 16 + t]) * longint'(xs[i - t]);
      end
    end
    acc = acc >>> 23;
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
    return int'(acc);
  endfunction

  // Monitor: logs handshakes, scores every output, checks latency, phase bases and handshake invariants.
  always @(negedge clk) begin
    if (rst) begin
      xs.delete();
      outs.delete();
      nout = 0;
      pend = 1'b0;
      prev_vld = 1'b0;
    end else begin
      check("no_in_rdy_with_out_vld", 32'(in_ready & out_valid), 0);
      if (in_ready || out_valid) check("rom_addr_idle_zero", 32'(rom_addr), 0);
      if (pend) begin
        check("rom_addr_phase_base", 32'(rom_addr), ((2 * nout) % 3) * 16);
        pend = 1'b0;
      end
      if (out_valid && !prev_vld) check("latency", cyc - trig_cyc, 18);
      prev_vld = out_valid;
      if (in_valid && in_ready) begin
        xs.push_back(int'($signed(in_data)));
        pend = 1'b1;
        trig_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        check("out_data_vs_model", 32'($signed(out_data)), model_out(nout));
        outs.push_back(int'($signed(out_data)));
        nout++;
        if ((2 * nout) % 3 == 2) begin
          pend = 1'b1;
          trig_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [23:0] d);
    bit got = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    check("send_handshake_in_time", 32'(got), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (in_ready && !out_valid) got = 1'b1;
    end
    check("idle_in_time", 32'(got), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    nfail++;
    $display("FAIL watchdog: run still active at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int xsz;
    logic [23:0] held;
    bit got;

    // Coefficients: phases 0/1 random and small enough never to saturate; phase 2 sums to 8830417 (> 2^23).
    for (int i = 0; i < 64; i++) rom[i] = 0;
    for (int i = 0; i < 32; i++) rom[i] = int'($urandom_range(800000, 0)) - 400000;
    for (int i = 32; i < 47; i++) rom[i] = 551901;
    rom[47] = 8830417 - 15 * 551901;
    rom[0]  = -1394906;
    rom[17] = 329876;
    rom[2]  = -251898;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_out_data", 32'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Input starvation in WAIT_IN.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("starve_in_ready", 32'(in_ready), 1);
      check("starve_out_valid", 32'(out_valid), 0);
      check("starve_out_data", 32'(out_data), 0);
    end
    check("starve_no_outputs", nout, 0);
    check("starve_no_inputs", xs.size(), 0);
    @(posedge clk);
    #1;

    // Impulse: 0.5 then zeros; outputs are coefficient words 0, 32, 17, 2 halved.
    send(24'h400000);
    for (int k = 0; k < 5; k++) send(24'h000000);
    in_valid = 1'b0;
    wait_idle();
    check("imp_out0", outs[0], -697453);
    check("imp_out1", outs[1], 275950);
    check("imp_out2", outs[2], 164938);
    check("imp_out3", outs[3], -125949);
    check("imp_out_count", nout, 9);
    check("imp_in_count", xs.size(), 6);

    // Backpressure: hold out_ready low for 50 cycles while an output is pending.
    out_ready = 1'b0;
    nb = nout;
    send(24'($urandom));
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check("bp_out_valid_seen", 32'(got), 1);
    held = out_data;
    xsz = xs.size();
    in_data = 24'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("bp_out_data_stable", 32'(out_data), 32'(held));
      check("bp_out_valid_held", 32'(out_valid), 1);
      check("bp_in_ready_low", 32'(in_ready), 0);
    end
    check("bp_no_input_taken", xs.size(), xsz);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("bp_outputs_after_release", nout - nb, 2);

    // Saturation: 20 samples of full-scale positive, then 20 of full-scale negative.
    do_reset();
    for (int k = 0; k < 20; k++) send(24'h7FFFFF);
    for (int k = 0; k < 20; k++) send(24'h800000);
    in_valid = 1'b0;
    wait_idle();
    check("sat_out_count", nout, 60);
    check("sat_pos_j25", outs[25], 8388607);
    check("sat_pos_j28", outs[28], 8388607);
    check("sat_neg_j55", outs[55], -8388608);
    check("sat_neg_j58", outs[58], -8388608);

    // Rate: 200 back-to-back random inputs give 300 outputs.
    nb = nout;
    for (int k = 0; k < 200; k++) send(24'($urandom));
    in_valid = 1'b0;
    wait_idle();
    check("rate_out_count", nout - nb, 300);

    // Reset in the middle of a MAC (tap 7 of a phase-0 pass).
    send(24'($urandom));
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midmac_rom_addr_tap7", 32'(rom_addr), 7);
    rst = 1'b1;
    #1;
    check("midmac_rst_out_valid", 32'(out_valid), 0);
    check("midmac_rst_in_ready", 32'(in_ready), 0);
    check("midmac_rst_rom_addr", 32'(rom_addr), 0);
    check("midmac_rst_out_data", 32'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(24'h400000);
    in_valid = 1'b0;
    wait_idle();
    check("midmac_imp_count", nout, 2);
    check("midmac_imp_out0", outs[0], -697453);
    check("midmac_imp_out1", outs[1], 275950);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
